// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_e;

  localparam int unsigned MAX_NDIG = 16;
  localparam logic [3:0]  BCD_NINE = 4'h9;

  // All-9s BCD value with ndig nibbles set; callers truncate to their own bus width.
  function automatic logic [4*MAX_NDIG-1:0] all_nines(input int unsigned ndig);
    logic [4*MAX_NDIG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_NDIG; i++) begin
      if (i < ndig) v[4*i +: 4] = BCD_NINE;
    end
    return v;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Divide-by-DIV prescaler; tc marks the last cycle of each count interval.
module sw_prescaler #(
  parameter int unsigned DIV = 10,
  parameter int unsigned PW  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          zero,
  output logic [PW-1:0] p,
  output logic          tc
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // Next count: zero wins, otherwise wrap-increment while enabled, else hold.
  always_comb begin
    p_d = p_q;
    if (zero) begin
      p_d = '0;
    end else if (en) begin
      p_d = (p_q == LAST) ? '0 : p_q + PW'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p  = p_q;
  assign tc = en & (p_q == LAST);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: button pulses to count enable, counter clear and lap display.
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned NDIG = 2,
  parameter int unsigned DIV  = 10,
  parameter int unsigned PW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  input  logic [4*NDIG-1:0] cnt_value,
  output logic              cnt_x,
  output logic              cnt_clr,
  output logic [4*NDIG-1:0] disp_out,
  output logic              running,
  output logic              ovf
);

  localparam int unsigned   W     = 4 * NDIG;
  localparam logic [W-1:0]  NINES = W'(all_nines(NDIG));

  sw_state_e      state_q, state_d;
  logic [W-1:0]   lap_q, lap_d;
  logic           ovf_q, ovf_d;
  logic           clr_q, clr_d;
  logic           presc_zero;
  logic [PW-1:0]  presc_p_unused;

  assign running    = (state_q == RUN) | (state_q == LAP);
  assign presc_zero = (state_q == IDLE) | clr_d;

  sw_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (running),
    .zero  (presc_zero),
    .p     (presc_p_unused),
    .tc    (cnt_x)
  );

  // Next-state, lap capture and overflow logic; clear > start_stop > lap.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_d = STOP;
        end else if (lap) begin
          state_d = LAP;
          lap_d   = cnt_value;
        end
      end
      LAP: begin
        if (start_stop)  state_d = STOP;
        else if (lap)    state_d = RUN;
      end
      STOP: begin
        if (clear) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_d) begin
      ovf_d = 1'b0;
    end else if (cnt_x && (cnt_value == NINES)) begin
      ovf_d = 1'b1;
    end
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      clr_q   <= clr_d;
    end
  end

  assign cnt_clr  = clr_q;
  assign ovf      = ovf_q;
  assign disp_out = (state_q == LAP) ? lap_q : cnt_value;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl with a BCD counter chain and a decimal reference model.
module tb_bcd_stopwatch_ctrl;

  localparam int unsigned NDIG = 2;
  localparam int unsigned DIV  = 4;
  localparam int unsigned PW   = 16;
  localparam int unsigned W    = 4 * NDIG;

  logic         clk;
  logic         reset;
  logic         start_stop;
  logic         lap;
  logic         clear;
  logic [W-1:0] cnt_value;
  logic         cnt_x;
  logic         cnt_clr;
  logic [W-1:0] disp_out;
  logic         running;
  logic         ovf;

  bcd_stopwatch_ctrl #(
    .NDIG (NDIG),
    .DIV  (DIV),
    .PW   (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .cnt_value  (cnt_value),
    .cnt_x      (cnt_x),
    .cnt_clr    (cnt_clr),
    .disp_out   (disp_out),
    .running    (running),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-digit BCD counter chain driven by the controller.
  always @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_value <= '0;
    end else if (cnt_x) begin
      if (cnt_value[3:0] == 4'h9) begin
        cnt_value[3:0] <= 4'h0;
        cnt_value[7:4] <= (cnt_value[7:4] == 4'h9) ? 4'h0 : cnt_value[7:4] + 4'h1;
      end else begin
        cnt_value[3:0] <= cnt_value[3:0] + 4'h1;
      end
    end
  end

  // Reference model: mode 0 idle, 1 run, 2 lap, 3 stop; values held as decimal integers.
  int m_mode, m_phase, m_val, m_lapv;
  bit m_ovf, m_clr, m_valid;
  int n_checks, n_err;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit ss, input bit lp, input bit cl);
    bit run_e, cx;
    int n_mode, n_phase, n_val, n_lapv;
    bit n_ovf, n_clr;
    reset = rst; start_stop = ss; lap = lp; clear = cl;
    #1;
    run_e = (m_mode == 1) || (m_mode == 2);
    cx    = run_e && (m_phase == DIV - 1);
    if (m_valid) begin
      chk("running",   32'(running),   32'(run_e));
      chk("cnt_x",     32'(cnt_x),     32'(cx));
      chk("cnt_clr",   32'(cnt_clr),   32'(m_clr));
      chk("ovf",       32'(ovf),       32'(m_ovf));
      chk("cnt_value", 32'(cnt_value), 32'(to_bcd(m_val)));
      chk("disp_out",  32'(disp_out),  32'(to_bcd(m_mode == 2 ? m_lapv : m_val)));
    end
    if (rst) begin
      n_mode = 0; n_phase = 0; n_val = 0; n_lapv = 0; n_ovf = 0; n_clr = 0;
    end else begin
      n_mode = m_mode; n_lapv = m_lapv; n_clr = 0;
      n_val   = m_clr ? 0 : (cx ? (m_val + 1) % 100 : m_val);
      n_ovf   = m_ovf || (cx && m_val == 99);
      n_phase = run_e ? (m_phase + 1) % DIV : m_phase;
      case (m_mode)
        0: if (ss) n_mode = 1;
        1: if (ss) n_mode = 3;
           else if (lp) begin n_mode = 2; n_lapv = m_val; end
        2: if (ss) n_mode = 3;
           else if (lp) n_mode = 1;
        default: if (cl) begin n_mode = 0; n_ovf = 0; n_clr = 1; end
                 else if (ss) n_mode = 1;
      endcase
      if (n_mode == 0) n_phase = 0;
    end
    @(posedge clk);
    m_mode = n_mode; m_phase = n_phase; m_val = n_val; m_lapv = n_lapv;
    m_ovf = n_ovf; m_clr = n_clr;
    if (rst) m_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held;
    int r;
    n_checks = 0; n_err = 0; m_valid = 1'b0;
    m_mode = 0; m_phase = 0; m_val = 0; m_lapv = 0; m_ovf = 0; m_clr = 0;
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    @(negedge clk);

    // Reset with every button pulsed.
    cycle(1, 1, 1, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 0, 0);
    chk("rst_running", 32'(running), 32'(0));
    chk("rst_disp",    32'(disp_out), 32'(cnt_value));

    // Start and run 40 clocks: ten counts.
    cycle(0, 1, 0, 0);
    repeat (40) cycle(0, 0, 0, 0);
    chk("count_40", 32'(cnt_value), 32'(8'h10));

    // Lap freeze at 0x23, release at 0x27.
    for (int i = 0; i < 200 && m_val != 23; i++) cycle(0, 0, 0, 0);
    chk("reach_23", 32'(cnt_value), 32'(8'h23));
    cycle(0, 0, 1, 0);
    repeat (16) cycle(0, 0, 0, 0);
    chk("lap_hold", 32'(disp_out), 32'(8'h23));
    chk("lap_live", 32'(cnt_value), 32'(8'h27));
    cycle(0, 0, 1, 0);
    chk("lap_release", 32'(disp_out), 32'(8'h27));
    chk("lap_running", 32'(running), 32'(1));

    // Stop mid-interval, hold, resume with the partial interval.
    for (int i = 0; i < 8 && m_phase != 2; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    held = cnt_value;
    repeat (20) cycle(0, 0, 0, 0);
    chk("stop_hold", 32'(cnt_value), 32'(held));
    cycle(0, 1, 0, 0);
    chk("resume_cx", 32'(cnt_x), 32'(1));

    // Clear ignored while running, honoured in stop.
    cycle(0, 0, 0, 1);
    chk("clr_run_ignored", 32'(running), 32'(1));
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    chk("clr_pulse", 32'(cnt_clr), 32'(1));
    cycle(0, 0, 0, 0);
    chk("clr_zero", 32'(cnt_value), 32'(8'h00));
    chk("clr_idle", 32'(running), 32'(0));

    // Overflow through 0x99 and stickiness across stop/start.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 500 && m_val != 98; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 20 && !m_ovf; i++) cycle(0, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'(1));
    chk("ovf_wrap", 32'(cnt_value), 32'(8'h00));
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("ovf_sticky", 32'(ovf), 32'(1));
    cycle(0, 1, 1, 0);
    chk("ss_beats_lap", 32'(running), 32'(0));
    chk("ss_lap_disp", 32'(disp_out), 32'(cnt_value));

    // Randomised button traffic against the model.
    repeat (1500) begin
      r = int'($urandom_range(0, 63));
      cycle(r == 63, (r < 2) || r == 10 || r == 11,
            (r >= 2 && r < 5) || r == 10,
            (r >= 5 && r < 8) || r == 11);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
